// File: rtl/nine_key_matrix_scanner.sv
// 3x3 push-button matrix scanner: drives one active-low column at a time, samples the rows,
// debounces whole frames and reports the debounced key mask plus a key code on each new press.
module nine_key_matrix_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rows_in,
    output logic [2:0] cols_out,
    output logic [8:0] keys,
    output logic       any_key,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE);

    typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2} col_e;

    col_e              col_q, col_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [2:0]        rows_s1_q, rows_s2_q;
    logic [8:0]        raw_q, raw_d;
    logic [8:0]        prev_q, prev_d;
    logic [8:0]        keys_q, keys_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    logic              any_q, any_d;
    logic              valid_q, valid_d;
    logic [3:0]        code_q, code_d;

    logic       sample;
    logic [8:0] frame;
    logic [8:0] new_bits;

    // Two-flop synchronizer on the asynchronous row senses; no reset needed on pure data.
    always_ff @(posedge clk) begin
        rows_s1_q <= rows_in;
        rows_s2_q <= rows_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= COL0;
            slot_q   <= '0;
            raw_q    <= '0;
            prev_q   <= '0;
            keys_q   <= '0;
            stable_q <= '0;
            any_q    <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            col_q    <= col_d;
            slot_q   <= slot_d;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            keys_q   <= keys_d;
            stable_q <= stable_d;
            any_q    <= any_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
        end
    end

    always_comb begin
        col_d    = col_q;
        slot_d   = slot_q + 1'b1;
        raw_d    = raw_q;
        prev_d   = prev_q;
        keys_d   = keys_q;
        stable_d = stable_q;
        any_d    = any_q;
        valid_d  = 1'b0;
        code_d   = code_q;

        sample = (slot_q == SLOT_LAST);
        // The frame in progress with the current column's rows merged in.
        frame = raw_q;
        for (int r = 0; r < 3; r++) begin
            frame[r * 3 + int'(col_q)] = ~rows_s2_q[r];
        end
        new_bits = frame & ~keys_q;

        if (sample) begin
            slot_d = '0;
            raw_d  = frame;
            case (col_q)
                COL0:    col_d = COL1;
                COL1:    col_d = COL2;
                default: col_d = COL0;
            endcase
        end

        if (sample && col_q == COL2) begin
            if (frame == prev_q) begin
                stable_d = (stable_q == STAB_MAX) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = STAB_W'(1);
            end
            prev_d = frame;
            if (stable_d == STAB_MAX && frame != keys_q) begin
                keys_d = frame;
                any_d  = |frame;
                if (new_bits != '0) begin
                    valid_d = 1'b1;
                    // Descending scan so the lowest newly pressed index wins.
                    for (int i = 8; i >= 0; i--) begin
                        if (new_bits[i]) code_d = 4'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        case (col_q)
            COL0:    cols_out = 3'b110;
            COL1:    cols_out = 3'b101;
            default: cols_out = 3'b011;
        endcase
    end

    assign keys      = keys_q;
    assign any_key   = any_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_nine_key_matrix_scanner.sv
// Bench for nine_key_matrix_scanner: a physical key matrix model drives the rows, and a
// frame-level reference of the debounce/press rules predicts keys, any_key, key_valid, key_code.
module tb_nine_key_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic       clk;
    logic       rst;
    logic [2:0] rows_in;
    logic [2:0] cols_out;
    logic [8:0] keys;
    logic       any_key;
    logic       key_valid;
    logic [3:0] key_code;

    logic [8:0] phys;

    int checks;
    int failures;

    // Reference state, one update per scanned frame.
    logic [8:0] m_keys;
    logic [8:0] m_prev;
    int         m_stable;
    logic       m_valid;
    logic [3:0] m_code;

    nine_key_matrix_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rows_in  (rows_in),
        .cols_out (cols_out),
        .keys     (keys),
        .any_key  (any_key),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows_in = 3'b111;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (phys[r * 3 + c] && !cols_out[c]) rows_in[r] = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] col_pattern(input int cyc);
        case ((cyc / SCAN_DIV) % 3)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic model_reset();
        m_keys   = '0;
        m_prev   = '0;
        m_stable = 0;
        m_valid  = 1'b0;
        m_code   = '0;
    endtask

    task automatic model_frame(input logic [8:0] f);
        logic [8:0] added;
        added = f & ~m_keys;
        if (f == m_prev) m_stable = (m_stable < DEBOUNCE) ? m_stable + 1 : DEBOUNCE;
        else             m_stable = 1;
        m_prev  = f;
        m_valid = 1'b0;
        if (m_stable == DEBOUNCE && f != m_keys) begin
            if (added != 0) begin
                m_valid = 1'b1;
                for (int i = 0; i < 9; i++) begin
                    if (added[i]) begin
                        m_code = 4'(i);
                        break;
                    end
                end
            end
            m_keys = f;
        end
    endtask

    // Called at the negedge of frame cycle 0; returns at the negedge of the next frame's cycle 0.
    task automatic run_frame(input logic [8:0] mask);
        phys = mask;
        for (int i = 0; i < FRAME; i++) begin
            check_val("cols", 32'(cols_out), 32'(col_pattern(i)));
            if (i == 0) begin
                check_val("keys_f0", 32'(keys), 32'(m_keys));
                check_val("any_f0", 32'(any_key), 32'(m_keys != 0));
                check_val("valid_f0", 32'(key_valid), 32'(m_valid));
                check_val("code_f0", 32'(key_code), 32'(m_code));
            end else begin
                check_val("valid_idle", 32'(key_valid), 32'd0);
                check_val("keys_hold", 32'(keys), 32'(m_keys));
            end
            @(posedge clk);
            @(negedge clk);
        end
        model_frame(mask);
    endtask

    // Reset pulse during COL1 slot 1, then resynchronise to frame cycle 0.
    task automatic reset_mid_frame(input logic [8:0] mask);
        phys = mask;
        for (int i = 0; i < SCAN_DIV + 1; i++) begin
            check_val("cols_pre_rst", 32'(cols_out), 32'(col_pattern(i)));
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("rst_cols", 32'(cols_out), 32'b110);
        check_val("rst_keys", 32'(keys), 32'd0);
        check_val("rst_any", 32'(any_key), 32'd0);
        check_val("rst_valid", 32'(key_valid), 32'd0);
        check_val("rst_code", 32'(key_code), 32'd0);
    endtask

    initial begin
        logic [8:0] rmask;
        checks   = 0;
        failures = 0;
        phys     = '0;
        rst      = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("reset_cols", 32'(cols_out), 32'b110);
        check_val("reset_keys", 32'(keys), 32'd0);
        check_val("reset_valid", 32'(key_valid), 32'd0);
        check_val("reset_code", 32'(key_code), 32'd0);

        // Idle scanning.
        repeat (4) run_frame(9'h000);

        // Single key 4 held.
        repeat (6) run_frame(9'h010);
        check_val("key4_keys", 32'(keys), 32'h010);
        repeat (3) run_frame(9'h000);

        // Key 0 bouncing on alternate frames, then held.
        for (int k = 0; k < 10; k++) run_frame((k % 2 == 0) ? 9'h001 : 9'h000);
        check_val("bounce_keys", 32'(keys), 32'h000);
        repeat (4) run_frame(9'h001);
        check_val("key0_keys", 32'(keys), 32'h001);
        repeat (3) run_frame(9'h000);

        // Simultaneous keys 2 and 6, then release.
        repeat (4) run_frame(9'h044);
        check_val("dual_code", 32'(key_code), 32'd2);
        repeat (4) run_frame(9'h000);
        check_val("dual_rel_any", 32'(any_key), 32'd0);

        // Key 8 held, reset mid-COL1, recovery.
        repeat (4) run_frame(9'h100);
        check_val("key8_keys", 32'(keys), 32'h100);
        reset_mid_frame(9'h100);
        repeat (4) run_frame(9'h100);
        check_val("key8_recov", 32'(key_code), 32'd8);

        // Key 3 held, then key 5 added.
        repeat (4) run_frame(9'h008);
        repeat (4) run_frame(9'h028);
        check_val("add5_keys", 32'(keys), 32'h028);
        check_val("add5_code", 32'(key_code), 32'd5);

        // Randomised patterns with held runs so debounce can settle.
        rmask = 9'(($urandom % 512));
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) rmask = 9'($urandom_range(0, 511));
            run_frame(rmask);
        end
        run_frame(9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
